// File: rtl/sdrx_frame.sv
// sdrx_frame: SD-style block-data receive framer.
// Waits for a start bit, then shifts in i_length bytes of data on 1, 4 or
// 8 lanes. Each completed 32-bit word is emitted with a one-cycle o_valid.
// The block's CRC-16 is checked on every active lane, then the end bit.
// The block closes with a one-cycle o_done, and o_err is qualified by o_done.
//
// Build option: define SDRX_FRAME_DDR_EN to honour i_ddr and i_nedge
// (double data rate, separate falling-edge CRCs). Without it, only SDR is
// built and i_ddr / i_nedge are ignored.
//
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_en                arm / hold a block receive (low aborts)
//   i_width, i_ddr,
//   i_length            bus width, DDR mode, block length (latched at start bit)
//   i_pedge, i_nedge    sample strobes for the sd_clk rising / falling edge
//   i_dat               lane samples
//   o_valid, o_data,
//   o_last              received word stream
//   o_done, o_err       end-of-block pulse and its error flag
//   o_busy              receiver is not idle
module sdrx_frame #(
    parameter int unsigned NUMIO = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic [1:0]  i_width,
    input  logic        i_ddr,
    input  logic [9:0]  i_length,
    input  logic        i_pedge,
    input  logic        i_nedge,
    input  logic [7:0]  i_dat,
    output logic        o_valid,
    output logic [31:0] o_data,
    output logic        o_last,
    output logic        o_done,
    output logic        o_err,
    output logic        o_busy
);

    localparam int unsigned CW   = 13;
    localparam int unsigned CRCW = 16;
    localparam logic [CRCW-1:0] POLY = 16'h1021;

    typedef enum logic [2:0] {IDLE, START, DATA, CRC, STOP, DONE} state_t;

    state_t          state;
    logic [1:0]      wsel_q;
    logic [7:0]      mask_q;
    logic [CW-1:0]   tot_q;
    logic [CW-1:0]   cnt;
    logic [31:0]     word_q;

    logic [1:0]      live_wsel;
    logic            start_hit;
    logic            in_frame;
    logic            neg_take;
    logic            take;
    logic [31:0]     word_nxt;
    logic            data_last;
    logic            crc_last;
    logic            end_bad;
    logic            crc_bad;
    logic            ddr_q;
    logic [NUMIO-1:0] nz_p;

    // Width code to lane-select: 0 = 1b, 1 = 4b, 2 = 8b; widths wider than NUMIO fall back to 1b.
    function automatic logic [1:0] decode_width(input logic [1:0] w);
        if (w == 2'b01 && NUMIO >= 4) return 2'd1;
        if (w == 2'b10 && NUMIO >= 8) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [7:0] lane_mask(input logic [1:0] ws);
        case (ws)
            2'd1:    return 8'h0F;
            2'd2:    return 8'hFF;
            default: return 8'h01;
        endcase
    endfunction

    // Data samples per block; a length of 0 encodes 512 bytes.
    function automatic logic [CW-1:0] block_samples(input logic [1:0] ws, input logic [9:0] len);
        logic [CW-1:0] bytes;
        bytes = (len == 10'd0) ? CW'(512) : CW'(len);
        case (ws)
            2'd1:    return CW'(bytes << 1);
            2'd2:    return bytes;
            default: return CW'(bytes << 3);
        endcase
    endfunction

    function automatic logic word_end(input logic [1:0] ws, input logic [CW-1:0] c);
        case (ws)
            2'd1:    return &c[2:0];
            2'd2:    return &c[1:0];
            default: return &c[4:0];
        endcase
    endfunction

    function automatic logic [31:0] shift_in(input logic [31:0] w, input logic [1:0] ws,
                                             input logic [7:0] d);
        case (ws)
            2'd1:    return {w[27:0], d[3:0]};
            2'd2:    return {w[23:0], d};
            default: return {w[30:0], d[0]};
        endcase
    endfunction

    function automatic logic [CRCW-1:0] crc_step(input logic [CRCW-1:0] c, input logic b);
        return {c[CRCW-2:0], 1'b0} ^ ((c[CRCW-1] ^ b) ? POLY : '0);
    endfunction

    assign live_wsel = decode_width(i_width);
    assign start_hit = i_pedge && ((i_dat & lane_mask(live_wsel)) == 8'h00);
    assign in_frame  = (state == DATA) || (state == CRC);
    assign take      = i_pedge | neg_take;
    assign word_nxt  = shift_in(word_q, wsel_q, i_dat);
    assign data_last = (CW'(cnt + 1'b1) == tot_q);
    assign crc_last  = (CW'(cnt + 1'b1) == (ddr_q ? CW'(32) : CW'(16)));
    assign end_bad   = ((i_dat & mask_q) != mask_q);

`ifdef SDRX_FRAME_DDR_EN
    logic             skip_q;
    logic [NUMIO-1:0] nz_n;

    // The falling-edge sample right after the start bit carries no data.
    assign neg_take = ddr_q & i_nedge & ~skip_q;
    assign crc_bad  = (|(nz_p & mask_q[NUMIO-1:0])) | (ddr_q & (|(nz_n & mask_q[NUMIO-1:0])));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ddr_q  <= 1'b0;
            skip_q <= 1'b0;
        end else if (state == START && start_hit) begin
            ddr_q  <= i_ddr;
            skip_q <= i_ddr;
        end else if (state == DATA && ddr_q && i_nedge && skip_q) begin
            skip_q <= 1'b0;
        end
    end
`else
    logic unused_ddr;

    assign ddr_q      = 1'b0;
    assign neg_take   = 1'b0;
    assign crc_bad    = |(nz_p & mask_q[NUMIO-1:0]);
    assign unused_ddr = ^{i_ddr, i_nedge};
`endif

    // Per-lane CRC-16 over data and CRC samples; a clean block leaves zero.
    for (genvar g = 0; g < NUMIO; g++) begin : g_lane
        logic [CRCW-1:0] crc_p;

        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset)                  crc_p <= '0;
            else if (state == START)      crc_p <= '0;
            else if (in_frame && i_pedge) crc_p <= crc_step(crc_p, i_dat[g]);
        end
        assign nz_p[g] = |crc_p;

`ifdef SDRX_FRAME_DDR_EN
        logic [CRCW-1:0] crc_n;

        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset)                   crc_n <= '0;
            else if (state == START)       crc_n <= '0;
            else if (in_frame && neg_take) crc_n <= crc_step(crc_n, i_dat[g]);
        end
        assign nz_n[g] = |crc_n;
`endif
    end

    // Frame FSM with registered outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= IDLE;
            wsel_q  <= 2'd0;
            mask_q  <= 8'h00;
            tot_q   <= '0;
            cnt     <= '0;
            word_q  <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
            if (!i_en && state != DONE) begin
                state  <= IDLE;
                o_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state  <= START;
                        o_busy <= 1'b1;
                    end
                    START: begin
                        cnt    <= '0;
                        word_q <= '0;
                        if (start_hit) begin
                            state  <= DATA;
                            wsel_q <= live_wsel;
                            mask_q <= lane_mask(live_wsel);
                            tot_q  <= block_samples(live_wsel, i_length);
                        end
                    end
                    DATA: begin
                        if (take) begin
                            word_q <= word_nxt;
                            cnt    <= CW'(cnt + 1'b1);
                            if (word_end(wsel_q, cnt)) begin
                                o_valid <= 1'b1;
                                o_data  <= word_nxt;
                                o_last  <= data_last;
                            end
                            if (data_last) begin
                                state <= CRC;
                                cnt   <= '0;
                            end
                        end
                    end
                    CRC: begin
                        if (take) begin
                            cnt <= CW'(cnt + 1'b1);
                            if (crc_last) begin
                                state <= STOP;
                                cnt   <= '0;
                            end
                        end
                    end
                    STOP: begin
                        if (i_pedge) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                            o_err  <= crc_bad | end_bad;
                        end
                    end
                    DONE: begin
                        state  <= i_en ? START : IDLE;
                        o_busy <= i_en;
                    end
                    default: begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdrx_frame.sv
// tb_sdrx_frame: randomized bench for sdrx_frame. Frames are built from a
// byte list. Lane CRCs come from polynomial long division, and the expected
// words are packed directly from the bytes. Define SDRX_FRAME_DDR_EN for
// both files to exercise the DDR build.
module tb_sdrx_frame;

`ifdef SDRX_FRAME_DDR_EN
    localparam bit DDR_ON = 1'b1;
`else
    localparam bit DDR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_en;
    logic [1:0]  i_width;
    logic        i_ddr;
    logic [9:0]  i_length;
    logic        i_pedge;
    logic        i_nedge;
    logic [7:0]  i_dat;
    logic        o_valid;
    logic [31:0] o_data;
    logic        o_last;
    logic        o_done;
    logic        o_err;
    logic        o_busy;

    always #5 clk = ~clk;

    sdrx_frame #(.NUMIO(8)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_en     (i_en),
        .i_width  (i_width),
        .i_ddr    (i_ddr),
        .i_length (i_length),
        .i_pedge  (i_pedge),
        .i_nedge  (i_nedge),
        .i_dat    (i_dat),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_last   (o_last),
        .o_done   (o_done),
        .o_err    (o_err),
        .o_busy   (o_busy)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] got_q[$];
    bit          last_q[$];
    int          done_cnt = 0;
    logic        err_seen = 1'b0;
    logic [7:0]  blk[$];
    logic [7:0]  tx_d[$];
    bit          tx_n[$];
    logic [31:0] exp_q[$];
    int          data_base;

    always @(negedge clk) begin
        if (o_valid) begin
            got_q.push_back(o_data);
            last_q.push_back(o_last);
        end
        if (o_done) begin
            done_cnt++;
            err_seen = o_err;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lanes_of(input int w);
        if (w == 1) return 4;
        if (w == 2) return 8;
        return 1;
    endfunction

    // Remainder of m(x) * x^16 divided by x^16 + x^12 + x^5 + 1.
    function automatic logic [15:0] crc_div(input bit m[$]);
        bit          r[$];
        logic [16:0] gen;
        logic [15:0] rem;
        gen = 17'h11021;
        r = m;
        for (int i = 0; i < 16; i++) r.push_back(1'b0);
        for (int i = 0; i < m.size(); i++)
            if (r[i])
                for (int j = 0; j <= 16; j++) r[i+j] = r[i+j] ^ gen[16-j];
        for (int j = 0; j < 16; j++) rem[15-j] = r[m.size()+j];
        return rem;
    endfunction

    task automatic push(input bit ne, input logic [7:0] d);
        tx_n.push_back(ne);
        tx_d.push_back(d);
    endtask

    // mode: 0 clean, 1 rising/only CRC bit flipped, 2 end bit low, 3 falling CRC bit flipped
    task automatic build(input int w, input bit ddr, input int len, input int mode, input int bad);
        int          lanes;
        logic [7:0]  mask;
        logic [7:0]  s;
        bit          lb[$];
        logic [15:0] crc [8][2];
        int          nc;
        int          e;
        int          bi;
        tx_d.delete();
        tx_n.delete();
        exp_q.delete();
        lanes = lanes_of(w);
        mask  = (lanes == 1) ? 8'h01 : (lanes == 4) ? 8'h0F : 8'hFF;
        push(1'b0, 8'hFF);
        if (ddr) push(1'b1, 8'($urandom));
        push(1'b0, 8'($urandom) & ~mask);
        if (ddr) push(1'b1, 8'($urandom));
        data_base = tx_d.size();
        for (int b = 0; b < len; b++) begin
            if (lanes == 1) begin
                for (int k = 7; k >= 0; k--) begin
                    s = 8'($urandom);
                    s[0] = blk[b][k];
                    push(ddr && ((tx_d.size() - data_base) % 2 == 1), s);
                end
            end else if (lanes == 4) begin
                s = 8'($urandom);
                s[3:0] = blk[b][7:4];
                push(ddr && ((tx_d.size() - data_base) % 2 == 1), s);
                s = 8'($urandom);
                s[3:0] = blk[b][3:0];
                push(ddr && ((tx_d.size() - data_base) % 2 == 1), s);
            end else begin
                push(ddr && ((tx_d.size() - data_base) % 2 == 1), blk[b]);
            end
        end
        for (int l = 0; l < lanes; l++) begin
            for (int ed = 0; ed < (ddr ? 2 : 1); ed++) begin
                lb.delete();
                for (int k = data_base; k < tx_d.size(); k++)
                    if (!ddr || ((k - data_base) % 2 == ed)) lb.push_back(tx_d[k][l]);
                crc[l][ed] = crc_div(lb);
            end
        end
        if (mode == 1) crc[bad][0] = crc[bad][0] ^ 16'h0400;
        if (mode == 3) crc[bad][1] = crc[bad][1] ^ 16'h0010;
        nc = ddr ? 32 : 16;
        for (int j = 0; j < nc; j++) begin
            e  = ddr ? (j % 2) : 0;
            bi = ddr ? (15 - j / 2) : (15 - j);
            s  = 8'($urandom);
            for (int l = 0; l < lanes; l++) s[l] = crc[l][e][bi];
            push(e == 1, s);
        end
        s = 8'($urandom) | mask;
        if (mode == 2) s[bad] = 1'b0;
        push(1'b0, s);
        for (int k = 0; k < len / 4; k++)
            exp_q.push_back({blk[4*k], blk[4*k+1], blk[4*k+2], blk[4*k+3]});
    endtask

    task automatic strobe(input bit ne, input logic [7:0] d, input bit junk);
        i_pedge = !ne;
        i_nedge = ne;
        i_dat   = d;
        tick();
        i_pedge = 1'b0;
        i_nedge = 1'b0;
        repeat ($urandom_range(0, 1)) begin
            i_nedge = junk & 1'($urandom_range(0, 1));
            i_dat   = 8'($urandom);
            tick();
        end
        i_nedge = 1'b0;
    endtask

    task automatic run_block(input string tag, input int w, input bit ddr, input int len,
                             input int mode, input int bad, input bit abort);
        bit ddr_eff;
        int spw;
        int n;
        ddr_eff = DDR_ON && ddr;
        spw = 32 / lanes_of(w);
        build(w, ddr_eff, len, mode, bad);
        got_q.delete();
        last_q.delete();
        done_cnt = 0;
        i_width  = 2'(w);
        i_ddr    = ddr;
        i_length = (len == 512 && $urandom_range(0, 1) == 1) ? 10'd0 : 10'(len);
        i_en     = 1'b1;
        tick();
        tick();
        check({tag, "_busy"}, 32'(o_busy), 32'd1);
        for (int i = 0; i < tx_d.size(); i++) begin
            strobe(tx_n[i], tx_d[i], !ddr_eff);
            if (i == data_base - 1) begin
                i_width  = 2'($urandom);
                i_ddr    = 1'($urandom);
                i_length = 10'($urandom);
            end
            if (abort && (i + 1 == data_base + 3 * spw)) break;
        end
        if (abort) begin
            i_en = 1'b0;
            tick();
            check({tag, "_abort_busy"}, 32'(o_busy), 32'd0);
            repeat (20) tick();
            check({tag, "_abort_done"}, 32'(done_cnt), 32'd0);
            check({tag, "_abort_words"}, 32'(got_q.size()), 32'd3);
            for (int i = 0; i < 3 && i < got_q.size(); i++)
                check({tag, "_abort_word"}, got_q[i], exp_q[i]);
            return;
        end
        for (int i = 0; i < 20 && done_cnt == 0; i++) tick();
        repeat (3) tick();
        check({tag, "_done"}, 32'(done_cnt), 32'd1);
        check({tag, "_err"}, 32'(err_seen), 32'(mode != 0));
        n = exp_q.size();
        check({tag, "_nwords"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            check({tag, "_word"}, got_q[i], exp_q[i]);
            check({tag, "_last"}, 32'(last_q[i]), 32'(i == n - 1));
        end
    endtask

    task automatic fill_random(input int len);
        blk.delete();
        for (int i = 0; i < len; i++) blk.push_back(8'($urandom));
    endtask

    initial begin
        rst      = 1'b1;
        i_en     = 1'b0;
        i_width  = 2'b00;
        i_ddr    = 1'b0;
        i_length = 10'd4;
        i_pedge  = 1'b0;
        i_nedge  = 1'b0;
        i_dat    = 8'h00;
        repeat (3) tick();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data", o_data, 32'd0);
        check("rst_last", 32'(o_last), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        check("idle_busy", 32'(o_busy), 32'd0);

        // 1b SDR single word, clean and with a corrupted CRC bit
        blk = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_block("w1", 0, 1'b0, 4, 0, 0, 1'b0);
        check("w1_word0", got_q.size() > 0 ? got_q[0] : 32'hX, 32'hDEADBEEF);
        blk = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_block("w1crc", 0, 1'b0, 4, 1, 0, 1'b0);

        // 4b SDR full 512-byte incrementing block
        blk.delete();
        for (int i = 0; i < 512; i++) blk.push_back(8'(i));
        run_block("w4big", 1, 1'b0, 512, 0, 0, 1'b0);
        check("w4big_first", got_q.size() > 0 ? got_q[0] : 32'hX, 32'h00010203);

        // 8b SDR with end bit low on lane 5 only
        fill_random(16);
        run_block("w8end", 2, 1'b0, 16, 2, 5, 1'b0);

        // abort after three words, then a clean block
        fill_random(16);
        run_block("abort", 0, 1'b0, 16, 0, 0, 1'b1);
        fill_random(16);
        run_block("after", 0, 1'b0, 16, 0, 0, 1'b0);

        // longest block: 4096 single-lane samples
        fill_random(512);
        run_block("w1big", 0, 1'b0, 512, 0, 0, 1'b0);

        if (DDR_ON) begin
            fill_random(8);
            run_block("ddr4", 1, 1'b1, 8, 0, 0, 1'b0);
            fill_random(8);
            run_block("ddr4neg", 1, 1'b1, 8, 3, 2, 1'b0);
        end

        for (int t = 0; t < 16; t++) begin
            int w;
            int ln;
            int md;
            int bl;
            bit dd;
            w  = $urandom_range(0, 3);
            dd = 1'($urandom_range(0, 1));
            ln = 4 * $urandom_range(1, 8);
            md = $urandom_range(0, 2);
            if (md == 1 && DDR_ON && dd && $urandom_range(0, 1) == 1) md = 3;
            bl = $urandom_range(0, lanes_of(w) - 1);
            fill_random(ln);
            run_block("rnd", w, dd, ln, md, bl, 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                i_en = 1'b0;
                tick();
                tick();
                check("rnd_idle_busy", 32'(o_busy), 32'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
